shift_reg_chain_ctrl: RTL and testbench
=======================================

// Module: shift_reg_chain_ctrl
// PURPOSE
//   Parametrised chain of NUM_REGS shift registers, each WIDTH bits, under a command FSM.
//   Supports hold, shift right, shift left and parallel load.
//   A start/count command runs an N-step shift burst with busy/done handshake.
//   Serial input is selectable between external serial_in and circular wrap.
//   Serves as a generic serialiser/rotator in the datapath.
// PARAMETERS
//   WIDTH     4  bits per register
//   NUM_REGS  2  registers in the chain (>=1)
//   CNT_W     4  width of the shift-count field
// PORTS
//   clk        in   1               clock; all state updates on posedge
//   rst        in   1               synchronous reset, active-high
//   start      in   1               command strobe; sampled only in IDLE
//   mode       in   2               00 hold, 01 shift right, 10 shift left, 11 parallel load
//   count      in   CNT_W           number of shift steps (shift modes only)
//   load_data  in   NUM_REGS*WIDTH  parallel load value, same packing as sr_q
//   serial_in  in   1               external serial bit (circ=0)
//   circ       in   1               1 = wrap chain end to chain start
//   sr_q       out  NUM_REGS*WIDTH  {R0,R1,...,R(NUM_REGS-1)}; R0 occupies the MSBs
//   so         out  NUM_REGS        so[k] = Rk[0], serial out of each register
//   busy       out  1               high while the FSM is in RUN
//   done       out  1               one-cycle pulse when a command completes
// BEHAVIOUR
//   Reset (rst=1 at posedge): sr_q=0, state=IDLE, busy=0, done=0.
//   - Reset overrides everything and aborts any command in flight.
//   FSM states: IDLE, RUN, DONE; busy = (state==RUN), done = (state==DONE).
//   IDLE, start=1 at edge E0: latch mode, count and load_data.
//   - load: next state RUN, steps=1.
//   - shift, count>0: next state RUN, steps=count.
//   - shift with count=0, or hold: next state DONE; sr_q unchanged.
//   RUN: each edge performs one step and decrements the step counter.
//   - Leave RUN for DONE on the edge that performs the final step.
//   DONE: lasts exactly one cycle, then returns to IDLE.
//   start is ignored in RUN and DONE (no queuing).
//   Timing: shift count c with start at E0 gives steps at E1..Ec.
//   - busy is high for c cycles; done is high in the cycle after Ec.
//   - A new start is accepted in the cycle after done.
//   - Load: busy for 1 cycle; data is visible when done rises.
//   Step definitions, with T = NUM_REGS*WIDTH:
//   - Shift right: sr_q <= {in, sr_q[T-1:1]}; in = circ ? sr_q[0] : serial_in.
//   - Shift left: sr_q <= {sr_q[T-2:0], in}; in = circ ? sr_q[T-1] : serial_in.
//   - Load: sr_q <= latched load_data.
//   serial_in and circ are sampled live at every step; they are not latched.
//   Each register's LSB feeds the next register's MSB on a right shift.
//   Rotating T steps with circ=1 restores the original value.
//   Outside RUN, sr_q holds its value.
// TESTING (WIDTH=4, NUM_REGS=2)
//   rst for 2 cycles mid-burst -> sr_q=8'h00, busy=0, done=0; next start accepted.
//   load 8'h5A -> busy 1 cycle, then done; sr_q=8'h5A, so=2'b01.
//   from 8'h5A: shift right count=1, circ=0, serial_in=0 -> sr_q=8'h2D.
//   from 8'h5A: shift left count=2, circ=0, serial_in=1 -> sr_q=8'h6B.
//   from 8'h5A: circ=1, shift right count=3 -> 8'h4B; count=8 -> 8'h5A.
//   - busy for 8 cycles, done 1 cycle later.
//   start pulsed during busy -> ignored; count=0 shift or hold -> done 1 cycle after start, sr_q unchanged.

Source files
------------

// File: rtl/shift_reg_chain_ctrl.sv
// shift_reg_chain_ctrl
// Chain of NUM_REGS registers of WIDTH bits each, driven by a small command
// FSM. A command is hold, shift right, shift left or parallel load. Shift
// commands run a burst of 'count' steps, and busy/done report progress.
// The serial input comes either from serial_in or from the far end of the
// chain (circular rotate).
module shift_reg_chain_ctrl #(
    parameter int WIDTH    = 4,
    parameter int NUM_REGS = 2,
    parameter int CNT_W    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [1:0]                mode,
    input  logic [CNT_W-1:0]          count,
    input  logic [NUM_REGS*WIDTH-1:0] load_data,
    input  logic                      serial_in,
    input  logic                      circ,
    output logic [NUM_REGS*WIDTH-1:0] sr_q,
    output logic [NUM_REGS-1:0]       so,
    output logic                      busy,
    output logic                      done
);

    localparam int T = NUM_REGS * WIDTH;

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [T-1:0]     load_q, load_d;
    logic [T-1:0]     sr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // The value shifted in at the chain end; serial_in and circ are live.
    logic             in_right;
    logic             in_left;

    assign in_right = circ ? sr_q[0]   : serial_in;
    assign in_left  = circ ? sr_q[T-1] : serial_in;

    // Next-state, step counter and datapath update for the command FSM.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        steps_d = steps_q;
        load_d  = load_q;
        sr_d    = sr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d = mode;
                    load_d = load_data;
                    if (mode == MODE_LOAD) begin
                        state_d = RUN;
                        steps_d = CNT_W'(1);
                    end else if ((mode != MODE_HOLD) && (count != '0)) begin
                        state_d = RUN;
                        steps_d = count;
                    end else begin
                        // Hold or a zero-length shift completes immediately.
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                case (mode_q)
                    MODE_RIGHT: sr_d = {in_right, sr_q[T-1:1]};
                    MODE_LEFT:  sr_d = {sr_q[T-2:0], in_left};
                    MODE_LOAD:  sr_d = load_q;
                    default:    sr_d = sr_q;
                endcase
                steps_d = steps_q - CNT_W'(1);
                if (steps_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // Single state register for FSM, latched command and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= MODE_HOLD;
            steps_q <= '0;
            load_q  <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            steps_q <= steps_d;
            load_q  <= load_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // Serial output of each register is its LSB; R0 sits in the MSBs.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_so
            assign so[gi] = sr_q[T - (gi + 1) * WIDTH];
        end
    endgenerate

endmodule

// File: tb/tb_shift_reg_chain_ctrl.sv
// tb_shift_reg_chain_ctrl
// Directed bench for shift_reg_chain_ctrl (WIDTH=4, NUM_REGS=2). Expected
// register contents come from a behavioural model and go through a queue
// that is popped when the DUT signals done.
module tb_shift_reg_chain_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [3:0] count;
    logic [7:0] load_data;
    logic       serial_in;
    logic       circ;
    logic [7:0] sr_q;
    logic [1:0] so;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] cur_exp;
    logic [7:0] sb[$];

    shift_reg_chain_ctrl #(.WIDTH(4), .NUM_REGS(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .count(count),
        .load_data(load_data), .serial_in(serial_in), .circ(circ),
        .sr_q(sr_q), .so(so), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] v, input logic [1:0] m,
                                         input logic [3:0] c, input logic [7:0] d,
                                         input logic si, input logic ci);
        logic [7:0] r;
        logic       b;
        r = v;
        if (m == 2'b11) begin
            r = d;
        end else if (m != 2'b00) begin
            for (int i = 0; i < int'(c); i++) begin
                if (m == 2'b01) begin
                    b = ci ? r[0] : si;
                    r = {b, r[7:1]};
                end else begin
                    b = ci ? r[7] : si;
                    r = {r[6:0], b};
                end
            end
        end
        return r;
    endfunction

    // Issue one command and check busy length, done pulse and final value.
    // With poke set, start is held high (as a load of 8'hFF) while busy.
    task automatic cmd(input string tag, input logic [1:0] m, input logic [3:0] c,
                       input logic [7:0] d, input logic si, input logic ci, input bit poke);
        int exp_busy;
        int busy_cnt;
        int guard;
        logic [7:0] exp_v;
        exp_busy = (m == 2'b11) ? 1 : ((m != 2'b00 && c != 0) ? int'(c) : 0);
        exp_v    = model(cur_exp, m, c, d, si, ci);
        sb.push_back(exp_v);
        cur_exp  = exp_v;
        @(negedge clk);
        mode = m; count = c; load_data = d; serial_in = si; circ = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cnt = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) busy_cnt++;
            if (poke && busy) begin
                start = 1'b1; mode = 2'b11; load_data = 8'hFF;
            end
            @(negedge clk);
            guard++;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        chk({tag, "_sr_q"}, {24'd0, sr_q}, {24'd0, sb.pop_front()});
        $display("cmd %s mode=%0d count=%0d sr_q=%02h busy_cycles=%0d", tag, m, c, sr_q, busy_cnt);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        chk({tag, "_sr_hold"}, {24'd0, sr_q}, {24'd0, cur_exp});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 2'b00; count = 4'd0;
        load_data = 8'h00; serial_in = 1'b0; circ = 1'b0;
        cur_exp = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_sr_q", {24'd0, sr_q}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        // Load, then abort a long rotate with reset part-way through.
        cmd("load_A5", 2'b11, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        mode = 2'b01; count = 4'd8; circ = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midburst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_sr_q", {24'd0, sr_q}, 32'h00);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        $display("reset mid-burst sr_q=%02h busy=%0b done=%0b", sr_q, busy, done);
        cur_exp = 8'h00;

        cmd("load_5A", 2'b11, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("so_5A", {30'd0, so}, 32'h1);
        cmd("shr1_si0", 2'b01, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("val_2D", {24'd0, sr_q}, 32'h2D);

        cmd("reload1", 2'b11, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        cmd("shl2_si1", 2'b10, 4'd2, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("val_6B", {24'd0, sr_q}, 32'h6B);

        cmd("reload2", 2'b11, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        cmd("rotr3", 2'b01, 4'd3, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("val_4B", {24'd0, sr_q}, 32'h4B);

        cmd("reload3", 2'b11, 4'd0, 8'h5A, 1'b0, 1'b0, 1'b0);
        cmd("rotr8_poke", 2'b01, 4'd8, 8'h00, 1'b1, 1'b1, 1'b1);
        chk("val_5A_rot", {24'd0, sr_q}, 32'h5A);

        cmd("rotl8", 2'b10, 4'd8, 8'h00, 1'b0, 1'b1, 1'b0);
        cmd("shl3_si0", 2'b10, 4'd3, 8'h00, 1'b0, 1'b0, 1'b0);
        cmd("shr15_si1", 2'b01, 4'd15, 8'h00, 1'b1, 1'b0, 1'b0);
        cmd("shr_cnt0", 2'b01, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        cmd("hold", 2'b00, 4'd5, 8'h33, 1'b1, 1'b0, 1'b0);
        cmd("load_C3", 2'b11, 4'd0, 8'hC3, 1'b0, 1'b0, 1'b0);
        chk("so_C3", {30'd0, so}, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
